fu_result_buffer: RTL and testbench
===================================

FU_RESULT_BUFFER -- requirements
Module: fu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 4, gives the number of buffered results; it SHALL be a power of two and at least 2.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 squash  input  1  flush request on branch mispredict; discards all entries.
REQ-005 fu_valid  input  1  functional unit offers a result this cycle.
REQ-006 fu_value  input  XLEN  result value.
REQ-007 fu_prf_idx  input  PRF_LEN  destination physical register.
REQ-008 fu_rob_idx  input  ROB_LEN  ROB tag.
REQ-009 fu_PC  input  XLEN  instruction PC.
REQ-010 fu_ready  output  1  buffer accepts a result this cycle.
REQ-011 cdb_gnt  input  1  CDB arbiter grant to this unit, the one-hot select bit for this unit.
REQ-012 out_valid  output  1  a head entry is presented to the CDB; this is the unit's request.
REQ-013 out_value, out_prf_idx, out_rob_idx, out_PC  outputs  XLEN/PRF_LEN/ROB_LEN/XLEN  head entry fields.
REQ-014 count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-015 The buffer SHALL be an in-order circular FIFO with head pointer, tail pointer and occupancy counter.
REQ-016 fu_ready SHALL equal (count != DEPTH); it is derived from registered state only.
REQ-017 An enqueue SHALL occur on a rising edge when fu_valid && fu_ready && !squash; the entry is written at tail and tail advances by 1.
REQ-018 A dequeue SHALL occur on a rising edge when cdb_gnt && out_valid && !squash; head advances by 1.
REQ-019 cdb_gnt while out_valid=0 SHALL be ignored, with no state change.
REQ-020 Simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-021 A full buffer SHALL NOT accept an enqueue even when a dequeue occurs in the same cycle, because fu_ready=0.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 out_valid SHALL equal (count != 0); out_* SHALL show the head entry when valid and all zeros when empty.
REQ-024 Latency: a result enqueued at edge N SHALL be presented at the earliest after edge N, with no combinational path from fu_* to out_*.
REQ-025 A granted result SHALL leave the outputs at that edge; the next entry, if any, SHALL appear in the following cycle.
REQ-026 squash SHALL take priority over enqueue and dequeue; at that edge head=tail=0 and count=0, and the fu_* offer in that cycle is dropped.
REQ-027 Entry order SHALL be preserved: results are broadcast in acceptance order.

Reset
REQ-028 Asserting reset (low) SHALL immediately and asynchronously clear head, tail, count and all stored entries, giving out_valid=0, out_*=0, count=0 and fu_ready=1.
REQ-029 Reset asserted mid-operation SHALL discard all entries; after release, the first accepted result SHALL occupy slot 0.

Structure
REQ-030 The shared package SHALL hold a packed typedef CDB_PACKET {value, prf_idx, rob_idx, PC} that both this block and the CDB use.
REQ-031 The shared package SHALL hold the XLEN, PRF_LEN and ROB_LEN constants.
REQ-032 The design SHALL be a single module with no sub-modules.
REQ-033 Storage SHALL be a flop array of CDB_PACKET indexed by $clog2(DEPTH)-bit pointers.

Verification
REQ-034 Reset, then enqueue rob 3 (value 0x11) and rob 5 (value 0x22) with no grant -> count=2, out_valid=1, out_rob_idx=3, fu_ready=1.
REQ-035 From that state, cdb_gnt=1 for two cycles -> out_rob_idx=5 after the first edge; out_valid=0, count=0 and out_*=0 after the second edge.
REQ-036 Fill DEPTH=4 entries -> fu_ready=0; fu_valid=1 and cdb_gnt=1 together -> count=3 and the offered result is not accepted.
REQ-037 Enqueue and dequeue in the same cycle, repeated for 10 cycles from count=1 -> count stays 1, pointers wrap, and rob order is preserved.
REQ-038 With count=3, squash=1 together with fu_valid=1 and cdb_gnt=1 -> count=0, out_valid=0, and neither the offer nor the dequeue takes effect.
REQ-039 Drive reset low asynchronously mid-cycle with count=2 -> out_valid=0 immediately; after release, a new enqueue is presented from slot 0.

Source files
------------

// File: rtl/fu_result_buffer_pkg.sv
// Shared CDB packet type and datapath widths used by the
// functional-unit result buffers and the CDB arbiter.
package fu_result_buffer_pkg;

  localparam int XLEN    = 32;
  localparam int PRF_LEN = 6;
  localparam int ROB_LEN = 5;

  typedef struct packed {
    logic [XLEN-1:0]    value;
    logic [PRF_LEN-1:0] prf_idx;
    logic [ROB_LEN-1:0] rob_idx;
    logic [XLEN-1:0]    PC;
  } CDB_PACKET;

endpackage

// File: rtl/fu_result_buffer.sv
// In-order result FIFO between a functional unit and the CDB;
// the head entry requests the CDB and leaves on grant.
module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               squash,
  input  logic               fu_valid,
  input  logic [XLEN-1:0]    fu_value,
  input  logic [PRF_LEN-1:0] fu_prf_idx,
  input  logic [ROB_LEN-1:0] fu_rob_idx,
  input  logic [XLEN-1:0]    fu_PC,
  output logic               fu_ready,
  input  logic               cdb_gnt,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_value,
  output logic [PRF_LEN-1:0] out_prf_idx,
  output logic [ROB_LEN-1:0] out_rob_idx,
  output logic [XLEN-1:0]    out_PC,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  CDB_PACKET entries_q [DEPTH];
  CDB_PACKET entries_d [DEPTH];
  CDB_PACKET fu_pkt;
  CDB_PACKET head_pkt;

  logic enq;
  logic deq;

  assign fu_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign enq = fu_valid && fu_ready && !squash;
  assign deq = cdb_gnt && out_valid && !squash;

  always_comb begin
    fu_pkt         = '0;
    fu_pkt.value   = fu_value;
    fu_pkt.prf_idx = fu_prf_idx;
    fu_pkt.rob_idx = fu_rob_idx;
    fu_pkt.PC      = fu_PC;
  end

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (enq) begin
      entries_d[tail_q] = fu_pkt;
      tail_d = tail_q + PW'(1);
    end
    if (deq) begin
      head_d = head_q + PW'(1);
    end
    // squash wins over any enqueue/dequeue computed above
    unique case (1'b1)
      squash: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      enq && !deq: count_d = count_q + CW'(1);
      deq && !enq: count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign head_pkt = out_valid ? entries_q[head_q] : '0;

  assign out_value   = head_pkt.value;
  assign out_prf_idx = head_pkt.prf_idx;
  assign out_rob_idx = head_pkt.rob_idx;
  assign out_PC      = head_pkt.PC;

endmodule

// File: tb/tb_fu_result_buffer.sv
// Randomized and directed bench for fu_result_buffer against
// a queue-based reference model.
module tb_fu_result_buffer;
  import fu_result_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic squash = 1'b0;
  logic fu_valid = 1'b0;
  logic [XLEN-1:0] fu_value = '0;
  logic [PRF_LEN-1:0] fu_prf_idx = '0;
  logic [ROB_LEN-1:0] fu_rob_idx = '0;
  logic [XLEN-1:0] fu_PC = '0;
  logic fu_ready;
  logic cdb_gnt = 1'b0;
  logic out_valid;
  logic [XLEN-1:0] out_value;
  logic [PRF_LEN-1:0] out_prf_idx;
  logic [ROB_LEN-1:0] out_rob_idx;
  logic [XLEN-1:0] out_PC;
  logic [CW-1:0] count;

  int total = 0;
  int bad = 0;
  CDB_PACKET mq[$];

  always #5 clk = ~clk;

  fu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .squash(squash),
    .fu_valid(fu_valid),
    .fu_value(fu_value),
    .fu_prf_idx(fu_prf_idx),
    .fu_rob_idx(fu_rob_idx),
    .fu_PC(fu_PC),
    .fu_ready(fu_ready),
    .cdb_gnt(cdb_gnt),
    .out_valid(out_valid),
    .out_value(out_value),
    .out_prf_idx(out_prf_idx),
    .out_rob_idx(out_rob_idx),
    .out_PC(out_PC),
    .count(count)
  );

  function automatic CDB_PACKET mk(input int rob, input int val);
    CDB_PACKET p;
    p.value   = XLEN'(val);
    p.prf_idx = PRF_LEN'($urandom);
    p.rob_idx = ROB_LEN'(rob);
    p.PC      = XLEN'($urandom);
    return p;
  endfunction

  function automatic CDB_PACKET outp();
    CDB_PACKET p;
    p = {out_value, out_prf_idx, out_rob_idx, out_PC};
    return p;
  endfunction

  function automatic CDB_PACKET expp();
    CDB_PACKET z;
    z = '0;
    return (mq.size() != 0) ? mq[0] : z;
  endfunction

  // Called at a negedge; drives one cycle and returns at the next negedge.
  task automatic cyc(input logic v, input logic g, input logic s,
                     input CDB_PACKET p);
    bit acc;
    bit rel;
    fu_valid   = v;
    cdb_gnt    = g;
    squash     = s;
    fu_value   = p.value;
    fu_prf_idx = p.prf_idx;
    fu_rob_idx = p.rob_idx;
    fu_PC      = p.PC;
    acc = v && (mq.size() != DEPTH) && !s;
    rel = g && (mq.size() != 0) && !s;
    @(posedge clk);
    if (s) mq.delete();
    else begin
      if (rel) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    @(negedge clk);
    fu_valid = 1'b0;
    cdb_gnt  = 1'b0;
    squash   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, count, fu_ready} !== {1'b0, CW'(0), 1'b1}) begin
      bad++;
      $display("FAIL reset_flags got v=%0b c=%0d r=%0b exp v=0 c=0 r=1",
               out_valid, count, fu_ready);
    end
    total++;
    if (outp() !== '0) begin
      bad++;
      $display("FAIL reset_out got=%h exp=0", outp());
    end
    rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
  endtask

  task automatic test_basic();
    CDB_PACKET p;
    p = mk(3, 'h11);
    fu_valid = 1'b1;
    fu_rob_idx = p.rob_idx;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL no_comb_path got out_valid=%0b exp=0", out_valid);
    end
    cyc(1, 0, 0, p);
    cyc(1, 0, 0, mk(5, 'h22));
    total++;
    if ({count, out_valid, out_rob_idx, fu_ready}
        !== {CW'(2), 1'b1, ROB_LEN'(3), 1'b1}) begin
      bad++;
      $display("FAIL two_enq got c=%0d v=%0b rob=%0d r=%0b exp 2 1 3 1",
               count, out_valid, out_rob_idx, fu_ready);
    end
    total++;
    if (out_value !== 32'h11) begin
      bad++;
      $display("FAIL head_value got=%h exp=11", out_value);
    end
    cyc(0, 1, 0, mk(0, 0));
    total++;
    if (out_rob_idx !== 5 || out_value !== 32'h22 || count !== 1) begin
      bad++;
      $display("FAIL first_gnt got rob=%0d val=%h c=%0d exp 5 22 1",
               out_rob_idx, out_value, count);
    end
    cyc(0, 1, 0, mk(0, 0));
    total++;
    if (out_valid !== 0 || count !== 0 || outp() !== '0) begin
      bad++;
      $display("FAIL second_gnt got v=%0b c=%0d out=%h exp 0 0 0",
               out_valid, count, outp());
    end
    cyc(0, 1, 0, mk(0, 0));
    total++;
    if (count !== 0 || out_valid !== 0 || fu_ready !== 1) begin
      bad++;
      $display("FAIL gnt_empty got c=%0d v=%0b exp c=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, mk(10 + i, 'h100 + i));
    total++;
    if (fu_ready !== 0 || count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL full got r=%0b c=%0d exp r=0 c=%0d",
               fu_ready, count, DEPTH);
    end
    cyc(1, 1, 0, mk(20, 'h999));
    total++;
    if (count !== 3 || out_rob_idx !== 11) begin
      bad++;
      $display("FAIL full_enq_deq got c=%0d rob=%0d exp c=3 rob=11",
               count, out_rob_idx);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (out_rob_idx !== ROB_LEN'(11 + i) || out_valid !== 1) begin
        bad++;
        $display("FAIL full_drain%0d got rob=%0d exp=%0d",
                 i, out_rob_idx, 11 + i);
      end
      cyc(0, 1, 0, mk(0, 0));
    end
    total++;
    if (out_valid !== 0 || count !== 0) begin
      bad++;
      $display("FAIL full_dropped got v=%0b c=%0d exp 0 0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, mk(1, 'h1));
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1, 0, mk(2 + i, 'h200 + i));
      total++;
      if (count !== 1 || out_rob_idx !== ROB_LEN'(2 + i)
          || outp() !== expp()) begin
        bad++;
        $display("FAIL b2b%0d got c=%0d rob=%0d exp c=1 rob=%0d",
                 i, count, out_rob_idx, 2 + i);
      end
    end
    cyc(0, 1, 0, mk(0, 0));
  endtask

  task automatic test_squash();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, mk(7 + i, 'h70 + i));
    cyc(1, 1, 1, mk(30, 'h300));
    total++;
    if (count !== 0 || out_valid !== 0 || outp() !== '0) begin
      bad++;
      $display("FAIL squash got c=%0d v=%0b out=%h exp 0 0 0",
               count, out_valid, outp());
    end
    cyc(1, 0, 0, mk(31, 'h310));
    total++;
    if (count !== 1 || out_rob_idx !== 31) begin
      bad++;
      $display("FAIL post_squash got c=%0d rob=%0d exp 1 31",
               count, out_rob_idx);
    end
    cyc(0, 1, 0, mk(0, 0));
  endtask

  task automatic test_async_reset();
    CDB_PACKET p;
    cyc(1, 0, 0, mk(12, 'h12));
    cyc(1, 0, 0, mk(13, 'h13));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 0 || count !== 0 || outp() !== '0
        || fu_ready !== 1) begin
      bad++;
      $display("FAIL async_rst got v=%0b c=%0d out=%h exp 0 0 0",
               out_valid, count, outp());
    end
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    p = mk(14, 'h14);
    cyc(1, 0, 0, p);
    total++;
    if (outp() !== p || count !== 1) begin
      bad++;
      $display("FAIL post_rst got=%h exp=%h", outp(), p);
    end
    cyc(0, 1, 0, mk(0, 0));
  endtask

  task automatic test_random();
    logic v, g, s;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 40) == 0);
      cyc(v, g, s, mk($urandom_range(0, 31), $urandom));
      total++;
      if (count !== CW'(mq.size())
          || out_valid !== (mq.size() != 0)
          || fu_ready !== (mq.size() != DEPTH)
          || outp() !== expp()) begin
        bad++;
        $display("FAIL rand%0d got c=%0d out=%h exp c=%0d out=%h",
                 i, count, outp(), mq.size(), expp());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_squash();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
